// File: rtl/preg_freelist.sv
// Physical register free list: a ring of preg numbers with up to two pops and
// two releases per cycle, plus per-branch head checkpoints for squash recovery.
module preg_freelist #(
    parameter int unsigned NUM_PREGS              = 64,
    parameter int unsigned MAX_PREDICT_DEPTH      = 4,
    localparam int unsigned PREG_W                 = $clog2(NUM_PREGS),
    localparam int unsigned PTR_W                  = PREG_W + 1,
    localparam int unsigned MAX_PREDICT_DEPTH_BITS = $clog2(MAX_PREDICT_DEPTH) + 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [1:0]                        alloc_req,
    output logic                              stalled,
    output logic [PREG_W-1:0]                 preg1,
    output logic [PREG_W-1:0]                 preg2,
    input  logic                              free1,
    input  logic [PREG_W-1:0]                 free1_addr,
    input  logic                              free2,
    input  logic [PREG_W-1:0]                 free2_addr,
    input  logic                              checkpoint,
    input  logic [MAX_PREDICT_DEPTH_BITS-1:0] checkpoint_tag,
    input  logic                              freelist_branch_shootdown,
    input  logic [MAX_PREDICT_DEPTH_BITS-1:0] freelist_shootdown_branch_tag,
    output logic [PTR_W-1:0]                  free_count
);

    localparam int unsigned TAG_W      = MAX_PREDICT_DEPTH_BITS;
    localparam int unsigned CKPT_IDX_W = (MAX_PREDICT_DEPTH > 1) ? $clog2(MAX_PREDICT_DEPTH) : 1;

    logic [PREG_W-1:0]     ring [NUM_PREGS];
    logic [PTR_W-1:0]      ckpt [MAX_PREDICT_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;

    logic [PREG_W-1:0]     head_idx;
    logic [PREG_W-1:0]     head_idx_p1;
    logic [PREG_W-1:0]     tail_idx;
    logic [PREG_W-1:0]     tail_idx_p1;

    logic                  shoot_valid;
    logic                  ckpt_valid;
    logic                  pop;
    logic [CKPT_IDX_W-1:0] shoot_idx;
    logic [CKPT_IDX_W-1:0] ckpt_idx;
    logic [PTR_W-1:0]      head_pop;
    logic [PTR_W-1:0]      head_next;
    logic [PTR_W-1:0]      tail_next;
    logic [PTR_W-1:0]      avail;
    logic                  push1;
    logic                  push2;
    logic [1:0]            push_n;
    logic [PTR_W:0]        count_after_push;
    logic                  overflow;
    logic                  push_ok;

    // A tag is meaningful only in 1..MAX_PREDICT_DEPTH; anything else is a no-op.
    function automatic logic tag_ok(input logic [TAG_W-1:0] tag);
        return (tag != '0) && (tag <= TAG_W'(MAX_PREDICT_DEPTH));
    endfunction

    // Allocation view: head and head+1 entries, stall judged on the registered count.
    assign head_idx    = head[PREG_W-1:0];
    assign head_idx_p1 = head_idx + PREG_W'(1);
    assign tail_idx    = tail[PREG_W-1:0];
    assign tail_idx_p1 = tail_idx + PREG_W'(1);
    assign preg1       = ring[head_idx];
    assign preg2       = ring[head_idx_p1];
    assign stalled     = free_count < PTR_W'(alloc_req);

    // Next head/tail: shootdown overrides pop and checkpoint, pushes always proceed.
    always_comb begin
        shoot_valid = freelist_branch_shootdown && tag_ok(freelist_shootdown_branch_tag);
        shoot_idx   = CKPT_IDX_W'(freelist_shootdown_branch_tag - TAG_W'(1));
        ckpt_valid  = checkpoint && !shoot_valid && tag_ok(checkpoint_tag);
        ckpt_idx    = CKPT_IDX_W'(checkpoint_tag - TAG_W'(1));

        pop       = (alloc_req != 2'd0) && !stalled && !shoot_valid;
        head_pop  = head + (pop ? PTR_W'(alloc_req) : '0);
        head_next = shoot_valid ? ckpt[shoot_idx] : head_pop;

        push1  = free1 && (free1_addr != '0);
        push2  = free2 && (free2_addr != '0);
        push_n = {1'b0, push1} + {1'b0, push2};

        // Capacity is judged against the head as it will be after this cycle.
        avail            = tail - head_next;
        count_after_push = {1'b0, avail} + (PTR_W + 1)'(push_n);
        overflow         = (push_n != 2'd0) && (count_after_push > (PTR_W + 1)'(NUM_PREGS - 1));
        push_ok          = (push_n != 2'd0) && !overflow;
        tail_next        = push_ok ? tail + PTR_W'(push_n) : tail;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head       <= '0;
            tail       <= PTR_W'(NUM_PREGS - 1);
            free_count <= PTR_W'(NUM_PREGS - 1);
        end else begin
            head       <= head_next;
            tail       <= tail_next;
            free_count <= tail_next - head_next;
        end
    end

    // Ring contents; the last slot resets to 0 and lies outside the initial free range.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_PREGS); i++) begin
                ring[i] <= PREG_W'(i + 1);
            end
        end else if (push_ok) begin
            if (push1) begin
                ring[tail_idx] <= free1_addr;
            end
            if (push2) begin
                ring[push1 ? tail_idx_p1 : tail_idx] <= free2_addr;
            end
        end
    end

    // Branch checkpoints capture the post-pop head.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(MAX_PREDICT_DEPTH); i++) begin
                ckpt[i] <= '0;
            end
        end else if (ckpt_valid) begin
            ckpt[ckpt_idx] <= head_pop;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            assert (alloc_req != 2'd3)
                else $error("preg_freelist: alloc_req=3 is not a legal request");
            assert (!overflow)
                else $warning("preg_freelist: free list overflow, release dropped");
        end
    end

endmodule

// File: tb/tb_preg_freelist.sv
// Directed bench for preg_freelist: allocation, stall, release, checkpoint
// recovery, overflow drop and reset priority against hand-computed values.
module tb_preg_freelist;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] alloc_req;
    logic       stalled;
    logic [5:0] preg1;
    logic [5:0] preg2;
    logic       free1;
    logic [5:0] free1_addr;
    logic       free2;
    logic [5:0] free2_addr;
    logic       checkpoint;
    logic [2:0] checkpoint_tag;
    logic       freelist_branch_shootdown;
    logic [2:0] freelist_shootdown_branch_tag;
    logic [6:0] free_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    preg_freelist dut (
        .clk                           (clk),
        .reset                         (reset),
        .alloc_req                     (alloc_req),
        .stalled                       (stalled),
        .preg1                         (preg1),
        .preg2                         (preg2),
        .free1                         (free1),
        .free1_addr                    (free1_addr),
        .free2                         (free2),
        .free2_addr                    (free2_addr),
        .checkpoint                    (checkpoint),
        .checkpoint_tag                (checkpoint_tag),
        .freelist_branch_shootdown     (freelist_branch_shootdown),
        .freelist_shootdown_branch_tag (freelist_shootdown_branch_tag),
        .free_count                    (free_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_req                     = 2'd0;
        free1                         = 1'b0;
        free1_addr                    = 6'd0;
        free2                         = 1'b0;
        free2_addr                    = 6'd0;
        checkpoint                    = 1'b0;
        checkpoint_tag                = 3'd0;
        freelist_branch_shootdown     = 1'b0;
        freelist_shootdown_branch_tag = 3'd0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (free_count !== 7'd63) begin errors++; $display("FAIL reset_count: got %0d expected 63", free_count); end
        checks++; if (preg1 !== 6'd1) begin errors++; $display("FAIL reset_preg1: got %0d expected 1", preg1); end
        checks++; if (preg2 !== 6'd2) begin errors++; $display("FAIL reset_preg2: got %0d expected 2", preg2); end
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL reset_stall0: got %0d expected 0", stalled); end
        alloc_req = 2'd2;
        #1;
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL reset_stall2: got %0d expected 0", stalled); end
        alloc_req = 2'd0;
        tick();
        checks++; if (free_count !== 7'd63) begin errors++; $display("FAIL reset_hold_count: got %0d expected 63", free_count); end
    endtask

    task automatic test_pop();
        alloc_req = 2'd2;
        tick();
        alloc_req = 2'd0;
        #1;
        checks++; if (preg1 !== 6'd3) begin errors++; $display("FAIL pop2_preg1: got %0d expected 3", preg1); end
        checks++; if (preg2 !== 6'd4) begin errors++; $display("FAIL pop2_preg2: got %0d expected 4", preg2); end
        checks++; if (free_count !== 7'd61) begin errors++; $display("FAIL pop2_count: got %0d expected 61", free_count); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 30; i++) begin
            alloc_req = 2'd2;
            tick();
        end
        alloc_req = 2'd0;
        #1;
        checks++; if (free_count !== 7'd1) begin errors++; $display("FAIL drain_count: got %0d expected 1", free_count); end
        alloc_req = 2'd2;
        #1;
        checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL stall_req2: got %0d expected 1", stalled); end
        tick();
        alloc_req = 2'd0;
        #1;
        checks++; if (free_count !== 7'd1) begin errors++; $display("FAIL stall_hold_count: got %0d expected 1", free_count); end
        checks++; if (preg1 !== 6'd63) begin errors++; $display("FAIL stall_hold_preg1: got %0d expected 63", preg1); end
        alloc_req = 2'd1;
        #1;
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL stall_req1: got %0d expected 0", stalled); end
        tick();
        #1;
        checks++; if (free_count !== 7'd0) begin errors++; $display("FAIL empty_count: got %0d expected 0", free_count); end
        checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL empty_stall: got %0d expected 1", stalled); end
        alloc_req = 2'd0;
        #1;
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL empty_noreq_stall: got %0d expected 0", stalled); end
    endtask

    task automatic test_free_same_cycle();
        free1      = 1'b1;
        free1_addr = 6'd5;
        free2      = 1'b1;
        free2_addr = 6'd9;
        alloc_req  = 2'd1;
        #1;
        checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL nobypass_stall: got %0d expected 1", stalled); end
        tick();
        idle_inputs();
        #1;
        checks++; if (free_count !== 7'd2) begin errors++; $display("FAIL free2_count: got %0d expected 2", free_count); end
        checks++; if (preg1 !== 6'd5) begin errors++; $display("FAIL free2_preg1: got %0d expected 5", preg1); end
        checks++; if (preg2 !== 6'd9) begin errors++; $display("FAIL free2_preg2: got %0d expected 9", preg2); end
    endtask

    task automatic test_free_single_and_zero();
        free1      = 1'b1;
        free1_addr = 6'd0;
        tick();
        idle_inputs();
        #1;
        checks++; if (free_count !== 7'd2) begin errors++; $display("FAIL free_zero_count: got %0d expected 2", free_count); end
        free2      = 1'b1;
        free2_addr = 6'd11;
        tick();
        idle_inputs();
        #1;
        checks++; if (free_count !== 7'd3) begin errors++; $display("FAIL free2_only_count: got %0d expected 3", free_count); end
        free1      = 1'b1;
        free1_addr = 6'd7;
        free2      = 1'b1;
        free2_addr = 6'd0;
        tick();
        idle_inputs();
        #1;
        checks++; if (free_count !== 7'd4) begin errors++; $display("FAIL free1_only_count: got %0d expected 4", free_count); end
        alloc_req = 2'd2;
        tick();
        alloc_req = 2'd0;
        #1;
        checks++; if (preg1 !== 6'd11) begin errors++; $display("FAIL free_order_preg1: got %0d expected 11", preg1); end
        checks++; if (preg2 !== 6'd7) begin errors++; $display("FAIL free_order_preg2: got %0d expected 7", preg2); end
        checks++; if (free_count !== 7'd2) begin errors++; $display("FAIL free_order_count: got %0d expected 2", free_count); end
    endtask

    task automatic test_checkpoint_shootdown();
        apply_reset();
        checkpoint     = 1'b1;
        checkpoint_tag = 3'd1;
        alloc_req      = 2'd2;
        tick();
        checkpoint = 1'b0;
        tick();
        tick();
        alloc_req = 2'd0;
        #1;
        checks++; if (free_count !== 7'd57) begin errors++; $display("FAIL ckpt_pre_count: got %0d expected 57", free_count); end
        // Pop and checkpoint in the shootdown cycle must both be ignored.
        freelist_branch_shootdown     = 1'b1;
        freelist_shootdown_branch_tag = 3'd1;
        alloc_req                     = 2'd2;
        checkpoint                    = 1'b1;
        checkpoint_tag                = 3'd2;
        tick();
        idle_inputs();
        #1;
        checks++; if (preg1 !== 6'd3) begin errors++; $display("FAIL shoot_preg1: got %0d expected 3", preg1); end
        checks++; if (free_count !== 7'd61) begin errors++; $display("FAIL shoot_count: got %0d expected 61", free_count); end
        freelist_branch_shootdown = 1'b1;
        tick();
        idle_inputs();
        #1;
        checks++; if (free_count !== 7'd61) begin errors++; $display("FAIL shoot_tag0_count: got %0d expected 61", free_count); end
        checks++; if (preg1 !== 6'd3) begin errors++; $display("FAIL shoot_tag0_preg1: got %0d expected 3", preg1); end
        freelist_branch_shootdown     = 1'b1;
        freelist_shootdown_branch_tag = 3'd2;
        tick();
        idle_inputs();
        #1;
        checks++; if (preg1 !== 6'd1) begin errors++; $display("FAIL shoot_tag2_preg1: got %0d expected 1", preg1); end
        checks++; if (free_count !== 7'd63) begin errors++; $display("FAIL shoot_tag2_count: got %0d expected 63", free_count); end
    endtask

    task automatic test_shootdown_push();
        alloc_req = 2'd2;
        tick();
        tick();
        alloc_req                     = 2'd0;
        freelist_branch_shootdown     = 1'b1;
        freelist_shootdown_branch_tag = 3'd1;
        free1                         = 1'b1;
        free1_addr                    = 6'd60;
        tick();
        idle_inputs();
        #1;
        checks++; if (preg1 !== 6'd3) begin errors++; $display("FAIL shoot_push_preg1: got %0d expected 3", preg1); end
        checks++; if (free_count !== 7'd62) begin errors++; $display("FAIL shoot_push_count: got %0d expected 62", free_count); end
    endtask

    task automatic test_overflow();
        apply_reset();
        free1      = 1'b1;
        free1_addr = 6'd5;
        tick();
        idle_inputs();
        #1;
        checks++; if (free_count !== 7'd63) begin errors++; $display("FAIL ovf_count: got %0d expected 63", free_count); end
        checks++; if (preg1 !== 6'd1) begin errors++; $display("FAIL ovf_preg1: got %0d expected 1", preg1); end
        // A same-cycle pop makes room for the release.
        alloc_req  = 2'd1;
        free1      = 1'b1;
        free1_addr = 6'd5;
        tick();
        idle_inputs();
        #1;
        checks++; if (free_count !== 7'd63) begin errors++; $display("FAIL poppush_count: got %0d expected 63", free_count); end
        checks++; if (preg1 !== 6'd2) begin errors++; $display("FAIL poppush_preg1: got %0d expected 2", preg1); end
        for (int i = 0; i < 31; i++) begin
            alloc_req = 2'd2;
            tick();
        end
        alloc_req = 2'd0;
        #1;
        checks++; if (free_count !== 7'd1) begin errors++; $display("FAIL wrap_count: got %0d expected 1", free_count); end
        checks++; if (preg1 !== 6'd5) begin errors++; $display("FAIL wrap_preg1: got %0d expected 5", preg1); end
    endtask

    task automatic test_reset_mid_drain();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            alloc_req = 2'd2;
            tick();
        end
        reset                         = 1'b1;
        freelist_branch_shootdown     = 1'b1;
        freelist_shootdown_branch_tag = 3'd1;
        tick();
        reset = 1'b0;
        idle_inputs();
        #1;
        checks++; if (free_count !== 7'd63) begin errors++; $display("FAIL midreset_count: got %0d expected 63", free_count); end
        checks++; if (preg1 !== 6'd1) begin errors++; $display("FAIL midreset_preg1: got %0d expected 1", preg1); end
        checks++; if (preg2 !== 6'd2) begin errors++; $display("FAIL midreset_preg2: got %0d expected 2", preg2); end
        alloc_req = 2'd2;
        #1;
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL midreset_stall: got %0d expected 0", stalled); end
        alloc_req = 2'd0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_pop();
        test_stall();
        test_free_same_cycle();
        test_free_single_and_zero();
        test_checkpoint_shootdown();
        test_shootdown_push();
        test_overflow();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/preg_freelist.md
PREG_FREELIST -- requirements
Module: preg_freelist

Interface
REQ-001 Parameter NUM_PREGS, default 64, number of physical registers; preg 0 is reserved and never allocated.
REQ-002 Parameter MAX_PREDICT_DEPTH, default 4, number of branch checkpoints; MAX_PREDICT_DEPTH_BITS = clog2(MAX_PREDICT_DEPTH)+1.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 alloc_req  in  2  number of pregs requested this cycle (0, 1 or 2; 3 is illegal).
REQ-006 stalled  out  1  combinational; 1 when free count < alloc_req.
REQ-007 preg1  out  clog2(NUM_PREGS)  combinational; entry at head.
REQ-008 preg2  out  clog2(NUM_PREGS)  combinational; entry at head+1.
REQ-009 free1 / free2  in  1 each  release strobe for free1_addr / free2_addr.
REQ-010 free1_addr / free2_addr  in  clog2(NUM_PREGS) each  preg being released by commit.
REQ-011 checkpoint  in  1  record the head pointer for checkpoint_tag.
REQ-012 checkpoint_tag  in  MAX_PREDICT_DEPTH_BITS  branch tag, 1..MAX_PREDICT_DEPTH.
REQ-013 freelist_branch_shootdown  in  1  restore head to the checkpoint for freelist_shootdown_branch_tag.
REQ-014 freelist_shootdown_branch_tag  in  MAX_PREDICT_DEPTH_BITS  tag being squashed.
REQ-015 free_count  out  clog2(NUM_PREGS)+1  registered; current number of free pregs.

Function
REQ-016 Storage: ring of NUM_PREGS entries; head and tail pointers are clog2(NUM_PREGS)+1 bits wide with a wrap bit; free_count = tail - head, modulo 2^(clog2(NUM_PREGS)+1).
REQ-017 Pop: when alloc_req != 0, stalled = 0 and no shootdown is asserted, head advances by alloc_req on the next edge.
REQ-018 When stalled = 1, the head does not move and the request is dropped; upstream holds it and retries.
REQ-019 preg2 is valid only when free_count >= 2; preg1 is valid only when free_count >= 1. Otherwise the value is don't-care.
REQ-020 Push, free1 only: write free1_addr at tail; tail += 1.
REQ-021 Push, free2 only: write free2_addr at tail; tail += 1.
REQ-022 Push, free1 and free2: write free1_addr at tail and free2_addr at tail+1; tail += 2.
REQ-023 Any free strobe whose address is 0 is ignored; it neither writes nor advances the tail.
REQ-024 A free arriving in the same cycle as a pop is not bypassed: it becomes visible on preg1/preg2 no earlier than the next cycle.
REQ-025 stalled uses the registered count only; a same-cycle free never clears stalled.
REQ-026 Overflow: a push that would make free_count exceed NUM_PREGS-1 is dropped and fires a simulation assertion.
REQ-027 Checkpoint: when checkpoint = 1, ckpt[checkpoint_tag-1] <= the head value after this cycle's pop.
REQ-028 Shootdown: when freelist_branch_shootdown = 1, head <= ckpt[freelist_shootdown_branch_tag-1].
REQ-029 During a shootdown, the same-cycle pop and checkpoint are ignored.
REQ-030 During a shootdown, same-cycle pushes still update the tail.
REQ-031 Shootdown with tag 0 is a no-op.
REQ-032 Pointer arithmetic wraps at NUM_PREGS entries; the extra pointer bit distinguishes full from empty.

Reset
REQ-033 Reset has priority over every other input, including a shootdown or pop in the same cycle.
REQ-034 After reset: ring[i] = i+1 for i = 0..NUM_PREGS-2; head = 0; tail = NUM_PREGS-1.
REQ-035 After reset: free_count = NUM_PREGS-1, preg1 = 1, preg2 = 2, stalled = 0 for any alloc_req.
REQ-036 After reset: all ckpt entries = 0.

Verification
REQ-037 Reset, then hold alloc_req = 0 -> free_count = 63, preg1 = 1, preg2 = 2, stalled = 0.
REQ-038 alloc_req = 2 for one cycle -> next cycle preg1 = 3, preg2 = 4, free_count = 61.
REQ-039 Pop until free_count = 1, then alloc_req = 2 -> stalled = 1, head unchanged; alloc_req = 1 -> stalled = 0, free_count = 0.
REQ-040 At free_count = 0: free1 = 1 with free1_addr = 5, free2 = 1 with free2_addr = 9, and alloc_req = 1 in the same cycle -> that cycle stalled = 1; next cycle free_count = 2, preg1 = 5, preg2 = 9.
REQ-041 After reset: checkpoint = 1 with tag 1 and alloc_req = 2 in the same cycle, then pop 4 more, then shootdown with tag 1 -> next cycle preg1 = 3, free_count = 61.
REQ-042 Free with address 0 -> tail unchanged. Push when free_count = 63 -> dropped and the assertion fires. Reset asserted mid-drain -> REQ-035 values on the next cycle.
